mem_port_arbiter: RTL and testbench

//  Shares one external cache-line memory port between the I-cache refill master and the D-cache master.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_grant.sv | 29 ++
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational I/D grant pick
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise D wins every tie.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic rr_ptr,
`endif
  output logic owner,
  output logic valid
);

  always_comb begin
    valid = i_req | d_req;
    owner = OWN_D;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      owner = rr_ptr;
`else
      owner = OWN_D;
`endif
    end else if (i_req) begin
      owner = OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one cache-line memory port between I-cache and D-cache
// MEM_ARB_ROUND_ROBIN_EN enables alternating grants on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              I_strobe_i,
  input  logic [XLEN-1:0]   I_addr_i,
  output logic              I_done_o,
  output logic [CLSIZE-1:0] I_data_o,
  input  logic              D_strobe_i,
  input  logic [XLEN-1:0]   D_addr_i,
  input  logic              D_rw_i,
  input  logic [CLSIZE-1:0] D_data_i,
  output logic              D_done_o,
  output logic [CLSIZE-1:0] D_data_o,
  output logic              M_strobe_o,
  output logic [XLEN-1:0]   M_addr_o,
  output logic              M_rw_o,
  output logic [CLSIZE-1:0] M_data_o,
  input  logic              M_done_i,
  input  logic [CLSIZE-1:0] M_data_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [XLEN-1:0]   addr_q;
  logic              rw_q;
  logic [CLSIZE-1:0] wdata_q;
  logic [CLSIZE-1:0] rdata_q;
  logic              grant_owner;
  logic              grant_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e rr_q;
`endif

  mem_arb_grant u_grant (
    .i_req  (I_strobe_i),
    .d_req  (D_strobe_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .rr_ptr (rr_q),
`endif
    .owner  (grant_owner),
    .valid  (grant_valid)
  );

  always_comb begin
    state_d    = state_q;
    M_strobe_o = 1'b0;
    I_done_o   = 1'b0;
    D_done_o   = 1'b0;
    I_data_o   = '0;
    D_data_o   = '0;
    case (state_q)
      ST_IDLE:  if (grant_valid) state_d = ST_ISSUE;
      ST_ISSUE: begin
        M_strobe_o = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT:  if (M_done_i) state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        if (owner_q == OWN_I) begin
          I_done_o = 1'b1;
          I_data_o = rdata_q;
        end else begin
          D_done_o = 1'b1;
          D_data_o = rdata_q;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign M_addr_o = addr_q;
  assign M_rw_o   = rw_q;
  assign M_data_o = wdata_q;
  assign busy_o   = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_D;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q    <= OWN_I;
`endif
    end else begin
      state_q <= state_d;
      // Requester inputs are only looked at here; afterwards the latched copy drives the port.
      if (state_q == ST_IDLE && grant_valid) begin
        owner_q <= owner_e'(grant_owner);
        if (grant_owner == OWN_D) begin
          addr_q  <= D_addr_i;
          rw_q    <= D_rw_i;
          wdata_q <= D_data_i;
        end else begin
          addr_q  <= I_addr_i;
          rw_q    <= 1'b0;
          wdata_q <= '0;
        end
      end
      if (state_q == ST_WAIT && M_done_i) rdata_q <= M_data_i;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (state_q == ST_RESP) rr_q <= other_owner(owner_q);
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int XLEN   = 32;
  localparam int CLSIZE = 64;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              I_strobe_i = 1'b0;
  logic [XLEN-1:0]   I_addr_i = '0;
  logic              I_done_o;
  logic [CLSIZE-1:0] I_data_o;
  logic              D_strobe_i = 1'b0;
  logic [XLEN-1:0]   D_addr_i = '0;
  logic              D_rw_i = 1'b0;
  logic [CLSIZE-1:0] D_data_i = '0;
  logic              D_done_o;
  logic [CLSIZE-1:0] D_data_o;
  logic              M_strobe_o;
  logic [XLEN-1:0]   M_addr_o;
  logic              M_rw_o;
  logic [CLSIZE-1:0] M_data_o;
  logic              M_done_i;
  logic [CLSIZE-1:0] M_data_i;
  logic              busy_o;

  logic              auto_resp = 1'b1;
  int                resp_delay = 3;
  logic              resp_done = 1'b0;
  logic [CLSIZE-1:0] resp_data = '0;
  logic              man_done = 1'b0;
  logic [CLSIZE-1:0] man_data = '0;
  logic              pend = 1'b0;
  int                cnt = 0;

  int i_done_cnt = 0, d_done_cnt = 0, both_cnt = 0, issue_cnt = 0;
  int checks = 0, passed = 0;

  assign M_done_i = resp_done | man_done;
  assign M_data_i = man_done ? man_data : resp_data;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i(clk_i), .rst_ni(rst_n),
    .I_strobe_i(I_strobe_i), .I_addr_i(I_addr_i), .I_done_o(I_done_o), .I_data_o(I_data_o),
    .D_strobe_i(D_strobe_i), .D_addr_i(D_addr_i), .D_rw_i(D_rw_i), .D_data_i(D_data_i),
    .D_done_o(D_done_o), .D_data_o(D_data_o),
    .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o), .M_data_o(M_data_o),
    .M_done_i(M_done_i), .M_data_i(M_data_i), .busy_o(busy_o)
  );

  function automatic logic [CLSIZE-1:0] exp_line(input logic [XLEN-1:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  // Memory model: answers each strobe resp_delay cycles later; shares the arbiter reset.
  always @(negedge clk_i) begin
    resp_done = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
      cnt  = 0;
    end else begin
      if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          resp_done = 1'b1;
          resp_data = exp_line(M_addr_o);
          pend      = 1'b0;
        end
      end
      if (M_strobe_o && auto_resp) begin
        pend = 1'b1;
        cnt  = resp_delay;
      end
    end
  end

  always @(negedge clk_i) begin
    if (I_done_o) i_done_cnt++;
    if (D_done_o) d_done_cnt++;
    if (I_done_o && D_done_o) both_cnt++;
    if (M_strobe_o) issue_cnt++;
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic wait_strobe(input int budget, output logic ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      if (M_strobe_o) begin
        ok = 1'b1;
        cyc = c;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output logic gi, output logic gd,
                           output logic [CLSIZE-1:0] di, output logic [CLSIZE-1:0] dd,
                           output int cyc);
    gi = 1'b0; gd = 1'b0; di = '0; dd = '0; cyc = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      if (I_done_o || D_done_o) begin
        gi = I_done_o; gd = D_done_o; di = I_data_o; dd = D_data_o; cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (busy_o !== 1'b0) $display("FAIL reset busy got=%0b exp=0", busy_o); else passed++;
    checks++; if (M_strobe_o !== 1'b0) $display("FAIL reset M_strobe got=%0b exp=0", M_strobe_o); else passed++;
    checks++; if ({I_done_o, D_done_o} !== 2'b00) $display("FAIL reset done got=%b exp=00", {I_done_o, D_done_o}); else passed++;
    checks++; if (M_addr_o !== '0) $display("FAIL reset M_addr got=%h exp=0", M_addr_o); else passed++;
    checks++; if ({M_rw_o, M_data_o} !== '0) $display("FAIL reset M_rw_data got=%h exp=0", {M_rw_o, M_data_o}); else passed++;
    checks++; if ({I_data_o, D_data_o} !== '0) $display("FAIL reset data_o got=%h exp=0", {I_data_o, D_data_o}); else passed++;
    @(negedge clk_i);
    rst_n = 1'b1;
    settle(2);
    checks++; if (busy_o !== 1'b0) $display("FAIL reset idle_after busy got=%0b exp=0", busy_o); else passed++;
  endtask

  task automatic test_d_write();
    logic ok, gi, gd;
    logic [CLSIZE-1:0] di, dd;
    int cyc, i0, d0;
    settle(1);
    i0 = i_done_cnt; d0 = d_done_cnt;
    resp_delay = 3;
    D_addr_i = 32'h8000_1000; D_rw_i = 1'b1; D_data_i = {8{8'hA5}}; D_strobe_i = 1'b1;
    wait_strobe(10, ok, cyc);
    checks++; if (!ok || cyc != 1) $display("FAIL d_write strobe_latency got=%0d exp=1", cyc); else passed++;
    checks++; if (M_rw_o !== 1'b1) $display("FAIL d_write rw got=%0b exp=1", M_rw_o); else passed++;
    checks++; if (M_addr_o !== 32'h8000_1000) $display("FAIL d_write addr got=%h exp=80001000", M_addr_o); else passed++;
    checks++; if (M_data_o !== {8{8'hA5}}) $display("FAIL d_write wdata got=%h exp=%h", M_data_o, {8{8'hA5}}); else passed++;
    wait_done(20, gi, gd, di, dd, cyc);
    D_strobe_i = 1'b0;
    checks++; if ({gi, gd} !== 2'b01) $display("FAIL d_write done got=%b exp=01", {gi, gd}); else passed++;
    checks++; if (dd !== exp_line(32'h8000_1000)) $display("FAIL d_write rdata got=%h exp=%h", dd, exp_line(32'h8000_1000)); else passed++;
    settle(4);
    checks++; if (d_done_cnt - d0 != 1) $display("FAIL d_write d_pulses got=%0d exp=1", d_done_cnt - d0); else passed++;
    checks++; if (i_done_cnt - i0 != 0) $display("FAIL d_write i_pulses got=%0d exp=0", i_done_cnt - i0); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL d_write busy_end got=%0b exp=0", busy_o); else passed++;
  endtask

  task automatic test_i_read();
    logic ok, gi, gd;
    logic [CLSIZE-1:0] di, dd;
    int cyc, i0;
    settle(1);
    i0 = i_done_cnt;
    resp_delay = 5;
    D_rw_i = 1'b1; D_data_i = '1;
    I_addr_i = 32'h8000_0040; I_strobe_i = 1'b1;
    wait_strobe(10, ok, cyc);
    checks++; if (!ok || cyc != 1) $display("FAIL i_read strobe_latency got=%0d exp=1", cyc); else passed++;
    checks++; if (M_rw_o !== 1'b0) $display("FAIL i_read rw got=%0b exp=0", M_rw_o); else passed++;
    checks++; if (M_addr_o !== 32'h8000_0040) $display("FAIL i_read addr got=%h exp=80000040", M_addr_o); else passed++;
    wait_done(20, gi, gd, di, dd, cyc);
    I_strobe_i = 1'b0;
    checks++; if ({gi, gd} !== 2'b10) $display("FAIL i_read done got=%b exp=10", {gi, gd}); else passed++;
    checks++; if (cyc != 6) $display("FAIL i_read done_latency got=%0d exp=6", cyc); else passed++;
    checks++; if (di !== exp_line(32'h8000_0040)) $display("FAIL i_read rdata got=%h exp=%h", di, exp_line(32'h8000_0040)); else passed++;
    @(negedge clk_i);
    checks++; if (I_done_o !== 1'b0) $display("FAIL i_read single_pulse got=%0b exp=0", I_done_o); else passed++;
    settle(3);
    checks++; if (i_done_cnt - i0 != 1) $display("FAIL i_read i_pulses got=%0d exp=1", i_done_cnt - i0); else passed++;
    D_rw_i = 1'b0; D_data_i = '0;
  endtask

  task automatic test_back_to_back_tie();
    logic gi, gd;
    logic [CLSIZE-1:0] di, dd, got, exp;
    logic [3:0] exp_d;
    int cyc, b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    settle(1);
    b0 = both_cnt;
    resp_delay = 2;
    I_addr_i = 32'h8000_0100; D_addr_i = 32'h8000_0200; D_rw_i = 1'b0;
    I_strobe_i = 1'b1; D_strobe_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(30, gi, gd, di, dd, cyc);
      if (k == 3) begin
        I_strobe_i = 1'b0; D_strobe_i = 1'b0;
      end
      got = gd ? dd : di;
      exp = exp_line(exp_d[k] ? 32'h8000_0200 : 32'h8000_0100);
      checks++; if ({gi, gd} !== {~exp_d[k], exp_d[k]}) $display("FAIL tie owner%0d got=%b exp=%b", k, {gi, gd}, {~exp_d[k], exp_d[k]}); else passed++;
      checks++; if (got !== exp) $display("FAIL tie data%0d got=%h exp=%h", k, got, exp); else passed++;
    end
    settle(4);
    checks++; if (busy_o !== 1'b0) $display("FAIL tie busy_end got=%0b exp=0", busy_o); else passed++;
    checks++; if (both_cnt - b0 != 0) $display("FAIL tie both_done got=%0d exp=0", both_cnt - b0); else passed++;
  endtask

  task automatic test_reset_mid();
    logic ok;
    int cyc, i0, d0, s0;
    settle(1);
    resp_delay = 20;
    D_addr_i = 32'h8000_3000; D_rw_i = 1'b0; D_strobe_i = 1'b1;
    wait_strobe(10, ok, cyc);
    repeat (2) @(negedge clk_i);
    checks++; if (busy_o !== 1'b1) $display("FAIL rst_mid busy_wait got=%0b exp=1", busy_o); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, M_strobe_o, D_done_o, I_done_o} !== 4'b0) $display("FAIL rst_mid async_ctl got=%b exp=0000", {busy_o, M_strobe_o, D_done_o, I_done_o}); else passed++;
    checks++; if (M_addr_o !== '0) $display("FAIL rst_mid async_addr got=%h exp=0", M_addr_o); else passed++;
    D_strobe_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    i0 = i_done_cnt; d0 = d_done_cnt; s0 = issue_cnt;
    settle(30);
    checks++; if ((i_done_cnt - i0) + (d_done_cnt - d0) != 0) $display("FAIL rst_mid stale_done got=%0d exp=0", (i_done_cnt - i0) + (d_done_cnt - d0)); else passed++;
    checks++; if (issue_cnt - s0 != 0) $display("FAIL rst_mid reissue got=%0d exp=0", issue_cnt - s0); else passed++;
  endtask

  task automatic test_spurious_done();
    int i0, d0;
    settle(1);
    auto_resp = 1'b0;
    i0 = i_done_cnt; d0 = d_done_cnt;
    man_data = 64'hDEAD_BEEF_0BAD_F00D; man_done = 1'b1;
    @(negedge clk_i);
    man_done = 1'b0;
    settle(2);
    checks++; if (busy_o !== 1'b0) $display("FAIL spur idle_busy got=%0b exp=0", busy_o); else passed++;
    checks++; if ((i_done_cnt - i0) + (d_done_cnt - d0) != 0) $display("FAIL spur idle_done got=%0d exp=0", (i_done_cnt - i0) + (d_done_cnt - d0)); else passed++;
    I_addr_i = 32'h8000_0400; I_strobe_i = 1'b1;
    @(negedge clk_i);
    checks++; if (M_strobe_o !== 1'b1) $display("FAIL spur issue_strobe got=%0b exp=1", M_strobe_o); else passed++;
    man_data = 64'h1111_2222_3333_4444; man_done = 1'b1;
    @(negedge clk_i);
    man_done = 1'b0;
    checks++; if ({busy_o, I_done_o} !== 2'b10) $display("FAIL spur issue_ignored got=%b exp=10", {busy_o, I_done_o}); else passed++;
    repeat (2) @(negedge clk_i);
    checks++; if ({busy_o, I_done_o} !== 2'b10) $display("FAIL spur still_wait got=%b exp=10", {busy_o, I_done_o}); else passed++;
    man_data = 64'hCAFE_F00D_1234_5678; man_done = 1'b1;
    @(negedge clk_i);
    man_done = 1'b0; I_strobe_i = 1'b0;
    checks++; if (I_done_o !== 1'b1) $display("FAIL spur real_done got=%0b exp=1", I_done_o); else passed++;
    checks++; if (I_data_o !== 64'hCAFE_F00D_1234_5678) $display("FAIL spur real_data got=%h exp=cafef00d12345678", I_data_o); else passed++;
    settle(3);
    checks++; if (i_done_cnt - i0 != 1) $display("FAIL spur i_pulses got=%0d exp=1", i_done_cnt - i0); else passed++;
    auto_resp = 1'b1;
  endtask

  task automatic test_drop_strobe();
    logic ok, gi, gd;
    logic [CLSIZE-1:0] di, dd;
    int cyc, d0, s0;
    settle(1);
    d0 = d_done_cnt; s0 = issue_cnt;
    resp_delay = 4;
    D_addr_i = 32'h8000_2000; D_rw_i = 1'b0; D_strobe_i = 1'b1;
    wait_strobe(10, ok, cyc);
    @(negedge clk_i);
    D_strobe_i = 1'b0;
    wait_done(20, gi, gd, di, dd, cyc);
    checks++; if ({gi, gd} !== 2'b01) $display("FAIL drop done got=%b exp=01", {gi, gd}); else passed++;
    checks++; if (dd !== exp_line(32'h8000_2000)) $display("FAIL drop rdata got=%h exp=%h", dd, exp_line(32'h8000_2000)); else passed++;
    settle(8);
    checks++; if (d_done_cnt - d0 != 1) $display("FAIL drop d_pulses got=%0d exp=1", d_done_cnt - d0); else passed++;
    checks++; if (issue_cnt - s0 != 1) $display("FAIL drop issues got=%0d exp=1", issue_cnt - s0); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL drop busy_end got=%0b exp=0", busy_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_d_write();
    test_i_read();
    test_back_to_back_tie();
    test_reset_mid();
    test_spurious_done();
    test_drop_strobe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
